// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: bus widths, tag codes,
// line geometry and the responder state encoding.
// MEM_RESPONDER_LATENCY_EN adds the DELAY state to the state enum.
package memory_responder_pkg;

    localparam int BUS_DATA_WIDTH   = 64;
    localparam int BUS_TAG_WIDTH    = 4;
    localparam int BEATS_PER_LINE   = 8;
    localparam int BEAT_BITS        = 3;
    localparam int LINE_OFFSET_BITS = 6;

    localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 4'h1;
    localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 4'h2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RESP    = 2'd2
`ifdef MEM_RESPONDER_LATENCY_EN
        ,
        DELAY   = 2'd3
`endif
    } resp_state_e;

endpackage

// File: rtl/memory_responder_array.sv
// Backing storage: LINES x 8 beats x 64 bits, one synchronous port.
// Read data is registered; a write returns the old contents.
module memory_responder_array
    import memory_responder_pkg::*;
#(
    parameter int LINES = 256
) (
    input  logic                                   clk_i,
    input  logic                                   we_i,
    input  logic [$clog2(LINES)+BEAT_BITS-1:0]     addr_i,
    input  logic [BUS_DATA_WIDTH-1:0]              wdata_i,
    output logic [BUS_DATA_WIDTH-1:0]              rdata_o
);

    logic [BUS_DATA_WIDTH-1:0] mem [LINES*BEATS_PER_LINE];
    logic [BUS_DATA_WIDTH-1:0] rdata_q;

    // Single port: write on we_i, always read the addressed beat.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts one line request at a time, stores 8 write
// beats or returns 8 read beats from memory_responder_array.
// MEM_RESPONDER_LATENCY_EN: insert a DELAY of LATENCY cycles (counted from
// the ack cycle, LATENCY >= 2) before the first read beat; without it the
// first beat follows the ack cycle directly and LATENCY is ignored.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int LINES   = 256,
    parameter int LATENCY = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bus_reqcyc,
    output logic                       bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]  bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]   bus_reqtag,
    output logic                       bus_respcyc,
    input  logic                       bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]  bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]   bus_resptag
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = BUS_DATA_WIDTH - LINE_OFFSET_BITS;

    resp_state_e               state_q, state_d;
    logic                      ack_q, ack_d;
    logic                      hdr_q, hdr_d;   // header acked, dispatch pending
    logic [LINE_W-1:0]         line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [BEAT_BITS-1:0]      beat_q, beat_d;

`ifdef MEM_RESPONDER_LATENCY_EN
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY);
    logic [CNT_W-1:0]          cnt_q, cnt_d;
`else
    localparam int lat_unused = LATENCY;
`endif

    logic                          mem_we;
    logic [IDX_W+BEAT_BITS-1:0]    mem_addr;
    logic [BUS_DATA_WIDTH-1:0]     mem_rdata;
    logic [IDX_W-1:0]              idx;
    logic                          unused_bits;

    // Address bits above the index wrap modulo LINES; byte offset is ignored.
    assign idx         = line_q[IDX_W-1:0];
    assign unused_bits = ^{bus_req[LINE_OFFSET_BITS-1:0], line_q[LINE_W-1:IDX_W]};

    // Writes use the current beat; reads prefetch the next-state beat so the
    // registered array output lines up with beat_q in RESP.
    assign mem_addr   = mem_we ? {idx, beat_q} : {idx, beat_d};
    assign bus_reqack = ack_q;

    memory_responder_array #(.LINES(LINES)) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (bus_req),
        .rdata_o (mem_rdata)
    );

    // Next-state, handshake and response outputs.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        hdr_d       = 1'b0;
        line_d      = line_q;
        tag_d       = tag_q;
        beat_d      = beat_q;
`ifdef MEM_RESPONDER_LATENCY_EN
        cnt_d       = cnt_q;
`endif
        mem_we      = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (hdr_q) begin
                    // Ack cycle: route on the latched tag; unknown tags stay idle.
                    if (tag_q == MEM_READ) begin
`ifdef MEM_RESPONDER_LATENCY_EN
                        state_d = DELAY;
                        cnt_d   = cnt_q - 1'b1;
`else
                        state_d = RESP;
`endif
                    end else if (tag_q == MEM_WRITE) begin
                        state_d = WR_DATA;
                    end
                end else if (bus_reqcyc && !ack_q) begin
                    ack_d  = 1'b1;
                    hdr_d  = 1'b1;
                    line_d = bus_req[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS];
                    tag_d  = bus_reqtag;
`ifdef MEM_RESPONDER_LATENCY_EN
                    cnt_d  = LAT_LD;
`endif
                end
            end
            WR_DATA: begin
                // !ack_q keeps a held beat from being taken twice.
                if (bus_reqcyc && !ack_q) begin
                    ack_d  = 1'b1;
                    mem_we = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) state_d = IDLE;
                end
            end
`ifdef MEM_RESPONDER_LATENCY_EN
            DELAY: begin
                if (cnt_q <= 1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RESP: begin
                bus_respcyc = 1'b1;
                bus_resp    = mem_rdata;
                bus_resptag = MEM_READ;
                if (bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and handshake registers; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            hdr_q   <= 1'b0;
            line_q  <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
`ifdef MEM_RESPONDER_LATENCY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            hdr_q   <= hdr_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
`ifdef MEM_RESPONDER_LATENCY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
